// File: rtl/gsensor_spi_if.sv
// Bus bundle between the accelerometer master (or bench) and the responder:
// 3-wire SPI pad signals, the sample feed and the interrupt pins.
interface gsensor_spi_if;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_sdio_in;
  logic        spi_sdio_out;
  logic        spi_sdio_oe;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        sample_valid;
  logic        int1;
  logic        int2;

  modport master (
    output spi_csn, spi_sclk, spi_sdio_in, sample_x, sample_y, sample_z, sample_valid,
    input  spi_sdio_out, spi_sdio_oe, int1, int2
  );

  modport slave (
    input  spi_csn, spi_sclk, spi_sdio_in, sample_x, sample_y, sample_z, sample_valid,
    output spi_sdio_out, spi_sdio_oe, int1, int2
  );
endinterface

// File: rtl/gsensor_spi_responder.sv
// ADXL345-style accelerometer stand-in: 3-wire SPI mode 3 slave with a small
// register map, coherent X/Y/Z sample registers and a DATA_READY interrupt.
module gsensor_spi_responder (
  input  logic         clock_50MHz,
  input  logic         reset,
  gsensor_spi_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

  // Synchronizers, packed as {csn, sclk, sdio}
  logic [2:0]  sync_meta_q, sync_meta_d, sync_q, sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic        armed_q, armed_d;
  logic        csn_s, sclk_s, sdio_s;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [5:0]  addr_q, addr_d;
  logic        mb_q, mb_d;
  logic        sdio_out_q, sdio_out_d;
  logic        sdio_oe_q, sdio_oe_d;

  logic [7:0]  bw_rate_q, bw_rate_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic [7:0]  int_enable_q, int_enable_d;
  logic [7:0]  int_map_q, int_map_d;
  logic [7:0]  data_format_q, data_format_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
  logic        pend_valid_q, pend_valid_d;
  logic        data_ready_q, data_ready_d;
  logic        int1_q, int1_d, int2_q, int2_d;

  // Control decode
  logic        active, rise, fall, byte_done, wr_en, tx_load, shift_out;
  logic [7:0]  rx_next;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        smp_apply;
  logic [15:0] smp_x, smp_y, smp_z;

  assign csn_s  = sync_q[2];
  assign sclk_s = sync_q[1];
  assign sdio_s = sync_q[0];

  // Input synchronizers, SCLK edge history and the post-reset arm flag
  always_comb begin
    sync_meta_d = {bus.spi_csn, bus.spi_sclk, bus.spi_sdio_in};
    sync_d      = sync_meta_q;
    sclk_prev_d = sclk_s;
    // Bus is ignored until CSN has been seen deasserted after reset
    armed_d     = armed_q | csn_s;
  end

  // FSM state register
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (csn_s) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (armed_q) state_d = StCmd;
        StCmd:   if (byte_done) state_d = rx_next[7] ? StRdata : StWdata;
        default: ;
      endcase
    end
  end

  // FSM outputs: per-cycle transfer control strobes and address sequencing
  always_comb begin
    active    = (state_q != StIdle) && !csn_s;
    rise      = active && sclk_s && !sclk_prev_q;
    fall      = active && !sclk_s && sclk_prev_q;
    rx_next   = {rx_sr_q[6:0], sdio_s};
    byte_done = rise && (bit_cnt_q == 3'd7);
    wr_en     = byte_done && (state_q == StWdata);
    shift_out = fall && (state_q == StRdata);
    tx_load   = 1'b0;
    addr_d    = addr_q;
    mb_d      = mb_q;
    rd_addr   = addr_q;
    if (byte_done) begin
      if (state_q == StCmd) begin
        addr_d  = rx_next[5:0];
        mb_d    = rx_next[6];
        rd_addr = rx_next[5:0];
        tx_load = rx_next[7];
      end else begin
        // 6-bit add wraps 0x3F -> 0x00 for free
        addr_d  = mb_q ? addr_q + 6'd1 : addr_q;
        rd_addr = addr_d;
        tx_load = (state_q == StRdata);
      end
    end
  end

  // Register read mux, addressed by the byte about to be shifted out
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      6'h00:   rd_data = 8'hE5;
      6'h2C:   rd_data = bw_rate_q;
      6'h2D:   rd_data = power_ctl_q;
      6'h2E:   rd_data = int_enable_q;
      6'h2F:   rd_data = int_map_q;
      6'h30:   rd_data = {data_ready_q, 7'd0};
      6'h31:   rd_data = data_format_q;
      6'h32:   rd_data = x_q[7:0];
      6'h33:   rd_data = x_q[15:8];
      6'h34:   rd_data = y_q[7:0];
      6'h35:   rd_data = y_q[15:8];
      6'h36:   rd_data = z_q[7:0];
      6'h37:   rd_data = z_q[15:8];
      default: ;
    endcase
  end

  // Shift registers and SDIO pad drive
  always_comb begin
    bit_cnt_d  = active ? (rise ? bit_cnt_q + 3'd1 : bit_cnt_q) : 3'd0;
    rx_sr_d    = rise ? rx_next : rx_sr_q;
    tx_sr_d    = tx_sr_q;
    sdio_out_d = sdio_out_q;
    sdio_oe_d  = sdio_oe_q;
    if (tx_load) begin
      tx_sr_d = rd_data;
    end else if (shift_out) begin
      tx_sr_d    = {tx_sr_q[6:0], 1'b0};
      sdio_out_d = tx_sr_q[7];
      sdio_oe_d  = 1'b1;
    end
    if (state_d == StIdle) sdio_oe_d = 1'b0;
  end

  // Config writes, sample buffering, DATA_READY and interrupt pins
  always_comb begin
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    int_map_d     = int_map_q;
    data_format_d = data_format_q;
    if (wr_en) begin
      case (addr_q)
        6'h2C:   bw_rate_d     = rx_next;
        6'h2D:   power_ctl_d   = rx_next;
        6'h2E:   int_enable_d  = rx_next;
        6'h2F:   int_map_d     = rx_next;
        6'h31:   data_format_d = rx_next;
        default: ;
      endcase
    end

    // Samples never land mid-transaction so a burst read stays coherent
    smp_apply    = 1'b0;
    smp_x        = bus.sample_x;
    smp_y        = bus.sample_y;
    smp_z        = bus.sample_z;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_z_d     = pend_z_q;
    pend_valid_d = pend_valid_q;
    if (state_q == StIdle) begin
      if (bus.sample_valid) begin
        smp_apply    = 1'b1;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        smp_apply    = 1'b1;
        smp_x        = pend_x_q;
        smp_y        = pend_y_q;
        smp_z        = pend_z_q;
        pend_valid_d = 1'b0;
      end
    end else if (bus.sample_valid) begin
      pend_x_d     = bus.sample_x;
      pend_y_d     = bus.sample_y;
      pend_z_d     = bus.sample_z;
      pend_valid_d = 1'b1;
    end
    x_d = smp_apply ? smp_x : x_q;
    y_d = smp_apply ? smp_y : y_q;
    z_d = smp_apply ? smp_z : z_q;

    // Set after clear so a coincident set wins
    data_ready_d = data_ready_q;
    if (tx_load && rd_addr >= 6'h32 && rd_addr <= 6'h37) data_ready_d = 1'b0;
    if (smp_apply && power_ctl_q[3]) data_ready_d = 1'b1;

    int1_d = data_format_q[5] ^ (data_ready_q & int_enable_q[7] & ~int_map_q[7]);
    int2_d = data_format_q[5] ^ (data_ready_q & int_enable_q[7] & int_map_q[7]);
  end

  // All datapath and register-file flops
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      // CSN sync resets low so the arm flag needs a real deassertion
      sync_meta_q   <= 3'b010;
      sync_q        <= 3'b010;
      sclk_prev_q   <= 1'b1;
      armed_q       <= 1'b0;
      bit_cnt_q     <= 3'd0;
      rx_sr_q       <= 8'h00;
      tx_sr_q       <= 8'h00;
      addr_q        <= 6'h00;
      mb_q          <= 1'b0;
      sdio_out_q    <= 1'b0;
      sdio_oe_q     <= 1'b0;
      bw_rate_q     <= 8'h0A;
      power_ctl_q   <= 8'h00;
      int_enable_q  <= 8'h00;
      int_map_q     <= 8'h00;
      data_format_q <= 8'h00;
      x_q           <= 16'h0000;
      y_q           <= 16'h0000;
      z_q           <= 16'h0000;
      pend_x_q      <= 16'h0000;
      pend_y_q      <= 16'h0000;
      pend_z_q      <= 16'h0000;
      pend_valid_q  <= 1'b0;
      data_ready_q  <= 1'b0;
      int1_q        <= 1'b0;
      int2_q        <= 1'b0;
    end else begin
      sync_meta_q   <= sync_meta_d;
      sync_q        <= sync_d;
      sclk_prev_q   <= sclk_prev_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      addr_q        <= addr_d;
      mb_q          <= mb_d;
      sdio_out_q    <= sdio_out_d;
      sdio_oe_q     <= sdio_oe_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      int_map_q     <= int_map_d;
      data_format_q <= data_format_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pend_z_q      <= pend_z_d;
      pend_valid_q  <= pend_valid_d;
      data_ready_q  <= data_ready_d;
      int1_q        <= int1_d;
      int2_q        <= int2_d;
    end
  end

  assign bus.spi_sdio_out = sdio_out_q;
  assign bus.spi_sdio_oe  = sdio_oe_q;
  assign bus.int1         = int1_q;
  assign bus.int2         = int2_q;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: drives SPI mode 3 transactions
// and sample strobes, checks returned bytes, SDIO enable and interrupt pins.
module tb_gsensor_spi_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] rbuf [8];
  logic [7:0] rx;
  logic       oe_all, oe_any, cmd_oe_any;

  gsensor_spi_if bus ();

  gsensor_spi_responder dut (
    .clock_50MHz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    bus.spi_csn = 1'b0;
    wait_clks(6);
  endtask

  task automatic spi_end();
    wait_clks(6);
    bus.spi_csn = 1'b1;
    wait_clks(8);
  endtask

  // Shift n bits: drive on SCLK fall, capture SDIO just before the rise
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] got,
                          output logic all_oe, output logic any_oe);
    got = 8'h00;
    all_oe = 1'b1;
    any_oe = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.spi_sclk    = 1'b0;
      bus.spi_sdio_in = tx[7-i];
      wait_clks(6);
      got    = {got[6:0], bus.spi_sdio_out};
      all_oe = all_oe & bus.spi_sdio_oe;
      any_oe = any_oe | bus.spi_sdio_oe;
      bus.spi_sclk = 1'b1;
      wait_clks(6);
    end
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
    logic [7:0] g;
    logic a, b;
    spi_begin();
    spi_bits({2'b00, addr}, 8, g, a, b);
    spi_bits(data, 8, g, a, b);
    spi_end();
  endtask

  task automatic strobe_sample(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z);
    bus.sample_x = x;
    bus.sample_y = y;
    bus.sample_z = z;
    bus.sample_valid = 1'b1;
    wait_clks(1);
    bus.sample_valid = 1'b0;
  endtask

  // Read n bytes into rbuf; optionally strobe a new sample after byte strobe_at
  task automatic spi_read(input logic [7:0] cmd, input int n, input int strobe_at,
                          input logic [15:0] nx, input logic [15:0] ny,
                          input logic [15:0] nz);
    logic [7:0] g;
    logic a, b;
    spi_begin();
    spi_bits(cmd, 8, g, a, b);
    cmd_oe_any = b;
    oe_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == strobe_at) strobe_sample(nx, ny, nz);
      spi_bits(8'h00, 8, g, a, b);
      rbuf[k] = g;
      oe_all  = oe_all & a;
    end
    spi_end();
  endtask

  initial begin
    bus.spi_csn      = 1'b1;
    bus.spi_sclk     = 1'b1;
    bus.spi_sdio_in  = 1'b0;
    bus.sample_x     = 16'h0000;
    bus.sample_y     = 16'h0000;
    bus.sample_z     = 16'h0000;
    bus.sample_valid = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);

    chk("rst_sdio_out", 16'(bus.spi_sdio_out), 16'h0);
    chk("rst_sdio_oe", 16'(bus.spi_sdio_oe), 16'h0);
    chk("rst_int1", 16'(bus.int1), 16'h0);
    chk("rst_int2", 16'(bus.int2), 16'h0);

    // DEVID read and SDIO enable window
    spi_read(8'h80, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("devid", 16'(rbuf[0]), 16'h00E5);
    chk("oe_cmd_low", 16'(cmd_oe_any), 16'h0);
    chk("oe_data_high", 16'(oe_all), 16'h1);
    chk("oe_after_end", 16'(bus.spi_sdio_oe), 16'h0);

    // RW register and RO register writes
    spi_write(6'h2D, 8'h08);
    spi_read(8'hAD, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("power_ctl", 16'(rbuf[0]), 16'h0008);
    spi_write(6'h00, 8'h55);
    spi_read(8'h80, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("devid_ro", 16'(rbuf[0]), 16'h00E5);
    spi_read(8'hAC, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("bw_rate_rst", 16'(rbuf[0]), 16'h000A);

    // Sample with MEASURE set, then burst read
    strobe_sample(16'h1234, 16'hFFFE, 16'h8001);
    wait_clks(2);
    spi_read(8'hB0, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("int_src_set", 16'(rbuf[0]), 16'h0080);
    spi_read(8'hF2, 6, -1, 16'h0, 16'h0, 16'h0);
    chk("mb_b0", 16'(rbuf[0]), 16'h0034);
    chk("mb_b1", 16'(rbuf[1]), 16'h0012);
    chk("mb_b2", 16'(rbuf[2]), 16'h00FE);
    chk("mb_b3", 16'(rbuf[3]), 16'h00FF);
    chk("mb_b4", 16'(rbuf[4]), 16'h0001);
    chk("mb_b5", 16'(rbuf[5]), 16'h0080);
    spi_read(8'hB0, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("int_src_clr", 16'(rbuf[0]), 16'h0000);

    // New sample mid-burst must not tear the read
    spi_read(8'hF2, 6, 2, 16'h5678, 16'h0001, 16'h7FFF);
    chk("coh_b0", 16'(rbuf[0]), 16'h0034);
    chk("coh_b1", 16'(rbuf[1]), 16'h0012);
    chk("coh_b2", 16'(rbuf[2]), 16'h00FE);
    chk("coh_b3", 16'(rbuf[3]), 16'h00FF);
    chk("coh_b4", 16'(rbuf[4]), 16'h0001);
    chk("coh_b5", 16'(rbuf[5]), 16'h0080);
    spi_read(8'hF2, 6, -1, 16'h0, 16'h0, 16'h0);
    chk("new_b0", 16'(rbuf[0]), 16'h0078);
    chk("new_b1", 16'(rbuf[1]), 16'h0056);
    chk("new_b2", 16'(rbuf[2]), 16'h0001);
    chk("new_b3", 16'(rbuf[3]), 16'h0000);
    chk("new_b4", 16'(rbuf[4]), 16'h00FF);
    chk("new_b5", 16'(rbuf[5]), 16'h007F);

    // Interrupt routing and polarity
    spi_write(6'h2E, 8'h80);
    spi_write(6'h2F, 8'h80);
    chk("int2_idle", 16'(bus.int2), 16'h0);
    strobe_sample(16'h00C3, 16'h0000, 16'h0000);
    wait_clks(4);
    chk("int2_dr", 16'(bus.int2), 16'h1);
    chk("int1_dr", 16'(bus.int1), 16'h0);
    spi_write(6'h31, 8'h20);
    chk("int2_inv", 16'(bus.int2), 16'h0);
    chk("int1_inv", 16'(bus.int1), 16'h1);
    spi_read(8'hB2, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("x_lo", 16'(rbuf[0]), 16'h00C3);
    chk("int2_inv_idle", 16'(bus.int2), 16'h1);
    chk("int1_inv_idle", 16'(bus.int1), 16'h1);

    // Address wrap on burst read
    spi_read(8'hFF, 2, -1, 16'h0, 16'h0, 16'h0);
    chk("wrap_3f", 16'(rbuf[0]), 16'h0000);
    chk("wrap_00", 16'(rbuf[1]), 16'h00E5);

    // Abort a write after 4 data bits
    spi_begin();
    spi_bits(8'h2E, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 4, rx, oe_all, oe_any);
    spi_end();
    chk("abort_oe", 16'(bus.spi_sdio_oe), 16'h0);
    spi_read(8'hAE, 1, -1, 16'h0, 16'h0, 16'h0);
    chk("abort_int_en", 16'(rbuf[0]), 16'h0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

Behavioural-synthesizable SPI responder that emulates the board accelerometer (ADXL345-compatible register map, 3-wire SPI mode 3) on the slave side of the accelerometer bus. It answers the accelerometer configuration/readback master with register reads and writes, and presents caller-supplied X/Y/Z samples and a data-ready interrupt. It is used as a bus-functional stand-in for the sensor in simulation and in FPGA loopback builds.

## Interface
- No parameters; register map and reset values are fixed below.
- `clock_50MHz`  in  1  system clock; all logic is clocked on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `spi_csn`  in  1  chip select from master, active low
- `spi_sclk`  in  1  SPI clock from master, idles high, ≤2 MHz
- `spi_sdio_in`  in  1  SDIO pad input
- `spi_sdio_out`  out  1  SDIO value driven by responder
- `spi_sdio_oe`  out  1  SDIO output enable; pad is driven only when 1
- `sample_x`, `sample_y`, `sample_z`  in  16 each  two's-complement samples
- `sample_valid`  in  1  one-cycle strobe: present a new X/Y/Z sample
- `int1`, `int2`  out  1 each  interrupt pins

## Operation
- Input sync: `spi_csn`, `spi_sclk`, `spi_sdio_in` each pass through 2 flops. SCLK rise/fall are detected on the synchronized copy.
- Transfer format: CPOL=1, CPHA=1, MSB first. The master's bit is sampled on SCLK rise. The responder changes `spi_sdio_out` on SCLK fall.
- First byte is the command: bit7 R/W (1=read), bit6 MB (multi-byte), bits5:0 address.
- Following bytes are data. With MB=1 the address increments after every data byte and wraps 0x3F→0x00. With MB=0 the address holds.
- FSM states:
  - IDLE → CMD on `spi_csn` falling.
  - CMD → WDATA or RDATA on the 8th SCLK rise.
  - WDATA/RDATA stay in their state for successive bytes.
  - Any state → IDLE when `spi_csn` is high.
- A 3-bit bit counter wraps every byte.
- Write path: on the 8th rise of a data byte, the shifted byte is committed to the address if that address is writable. Writes to any other address are discarded.
- Read path: on the byte-completing rise (command or previous data byte), `tx_sr` is loaded with reg[addr]. On each SCLK fall in RDATA, `spi_sdio_out` takes `tx_sr[7]` and `tx_sr` shifts left. `spi_sdio_oe` sets on the first fall in RDATA and clears on entry to IDLE.
- Register map (unlisted addresses read 0x00, writes ignored):
  - 0x00 DEVID: RO 0xE5
  - 0x2C BW_RATE: RW, reset 0x0A
  - 0x2D POWER_CTL: RW, reset 0x00; bit3 = MEASURE
  - 0x2E INT_ENABLE: RW, reset 0x00
  - 0x2F INT_MAP: RW, reset 0x00
  - 0x30 INT_SOURCE: RO; bit7 = DATA_READY, other bits 0
  - 0x31 DATA_FORMAT: RW, reset 0x00; bit5 = INT_INVERT
  - 0x32–0x37: X lo, X hi, Y lo, Y hi, Z lo, Z hi (little-endian); reset 0x00
- Sample buffering: a `sample_valid` strobe in IDLE loads the data registers directly. A strobe during a transaction is stored in a one-deep pending buffer, and a later strobe overwrites it (newest wins). The pending buffer is applied in the first cycle of IDLE. This keeps a multi-byte read coherent.
- DATA_READY:
  - Set when a sample is applied while MEASURE=1.
  - Cleared when `tx_sr` is loaded from any address 0x32–0x37.
  - Set and clear in the same cycle: set wins.
- Interrupts:
  - `int1` = INT_INVERT ^ (DATA_READY & INT_ENABLE[7] & ~INT_MAP[7])
  - `int2` = INT_INVERT ^ (DATA_READY & INT_ENABLE[7] & INT_MAP[7])

## Timing
- Reset values: state IDLE, `spi_sdio_out`=0, `spi_sdio_oe`=0, `int1`=0, `int2`=0, registers as listed, pending buffer empty.
- SCLK high and low phases are each ≥4 `clock_50MHz` cycles.
- `spi_sdio_out` updates 3 cycles after the pad SCLK fall (2 sync + 1 register), within the 250 ns half-period at 2 MHz.
- `spi_csn` rising mid-byte aborts the transfer: the partial byte is discarded, completed bytes stay committed, and `spi_sdio_oe` drops 3 cycles after the pad edge.
- Register writes take effect in the cycle after the committing rise. Interrupt outputs are registered and follow DATA_READY/config changes by 1 cycle.
- Reset asserted mid-transfer forces the reset values immediately. The bus is ignored until `spi_csn` has been seen high after reset is released.

## Test plan
- Read 0x00 (cmd 0x80) → 8 bits 0xE5 returned on SDIO, `spi_sdio_oe` high only during the data byte.
- Write 0x08 to 0x2D, then read 0x2D → 0x08. Write 0x55 to 0x00, then read → 0xE5 (write ignored).
- MEASURE=1, sample X=0x1234, Y=0xFFFE, Z=0x8001, then MB read from 0x32 (cmd 0xF2), 6 bytes → 34 12 FE FF 01 80; DATA_READY reads 0 afterwards.
- Same 6-byte MB read with a new `sample_valid` mid-transfer → all 6 bytes from the old sample; a following read returns the new sample.
- INT_ENABLE=0x80, INT_MAP=0x80, then sample → `int2`=1, `int1`=0. Set DATA_FORMAT=0x20 → `int2`=0, `int1`=1. Reading 0x32 → `int2`=1 (inverted idle).
- MB read starting at 0x3F for 2 bytes → 0x00 then 0xE5 (wrap). `spi_csn` raised after 4 bits of a write to 0x2E → register unchanged, `spi_sdio_oe`=0, next transaction decodes normally.
